// File: rtl/data_bus_responder.sv
`default_nettype none
// data_bus_responder: wait-stated 32-bit data memory slave with byte/half/word stores. Rev 1.0
// Optional DATA_RESP_BOUNDS_EN adds an out-of-range response that pulses MemError with MemReady.
module data_bus_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        MemReadEn,
  input  logic        MemWriteEn,
  input  logic [3:0]  storetype,
  input  logic [31:0] AddressBus,
  input  logic [31:0] DataMemoryInput,
  output logic [31:0] DataMemoryOutput,
  output logic        MemReady,
  output logic        MemError
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   data_q;
  logic [3:0]    type_q;
  logic          wr_q;
  logic [31:0]   rdata_q;
  logic          ready_q;

  logic [31:0]   mem_q [DEPTH];

  logic          req;
  logic          in_idle;
  logic          accept;
  logic          abort;
  logic          enter_resp;
  logic          commit;

  logic [AW+1:0] acc_addr;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_data;
  logic [3:0]    acc_type;
  logic          acc_wr;
  logic          acc_oob;
  logic [3:0]    be;
  logic [31:0]   wdata;

  assign req     = MemReadEn | MemWriteEn;
  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && req;
  assign abort   = (state_q == WAIT) && !req;

  // With zero wait states the access completes on its capture edge, so the live bus is used.
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && req && (cnt_q == LAST_WAIT));

  assign acc_addr = in_idle ? AddressBus[AW+1:0] : addr_q;
  assign acc_data = in_idle ? DataMemoryInput    : data_q;
  assign acc_type = in_idle ? storetype          : type_q;
  assign acc_wr   = in_idle ? MemWriteEn         : wr_q;
  assign acc_idx  = acc_addr[AW+1:2];

`ifdef DATA_RESP_BOUNDS_EN
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  logic oob_now;
  logic oob_q;
  logic err_q;

  assign oob_now  = ({1'b0, AddressBus} >= LIMIT);
  assign acc_oob  = in_idle ? oob_now : oob_q;
  assign MemError = err_q;
`else
  logic unused_addr;

  assign unused_addr = ^AddressBus[31:AW+2];
  assign acc_oob     = 1'b0;
  assign MemError    = 1'b0;
`endif

  always_comb begin
    be    = 4'b1111;
    wdata = acc_data;
    case (acc_type)
      4'b0000: begin
        be    = 4'b0001 << acc_addr[1:0];
        wdata = {4{acc_data[7:0]}};
      end
      4'b0001: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{acc_data[15:0]}};
      end
      default: ;
    endcase
  end

  // rst gates the commit so a zero-wait request seen during reset cannot write storage.
  assign commit = rst && enter_resp && acc_wr && !acc_oob;

  always_ff @(posedge clock) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[acc_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      type_q  <= 4'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
`ifdef DATA_RESP_BOUNDS_EN
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DATA_RESP_BOUNDS_EN
      err_q   <= 1'b0;
`endif
      if (accept) begin
        addr_q <= AddressBus[AW+1:0];
        data_q <= DataMemoryInput;
        type_q <= storetype;
        wr_q   <= MemWriteEn;
`ifdef DATA_RESP_BOUNDS_EN
        oob_q  <= oob_now;
`endif
      end
      if (enter_resp) begin
        state_q <= RESP;
        cnt_q   <= 4'd0;
        ready_q <= 1'b1;
        if (acc_oob) begin
          rdata_q <= 32'h0;
        end else if (!acc_wr) begin
          rdata_q <= mem_q[acc_idx];
        end
`ifdef DATA_RESP_BOUNDS_EN
        err_q   <= acc_oob;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q <= WAIT;
              cnt_q   <= 4'd0;
            end
          end
          WAIT: begin
            if (abort) begin
              state_q <= IDLE;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          RESP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign DataMemoryOutput = rdata_q;
  assign MemReady         = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// Bench for data_bus_responder: two instances (WAIT_CYCLES=2 and 0) driven with directed and
// random traffic; a scoreboard compares each MemReady response with a byte-lane memory model.
module tb_data_bus_responder;

  localparam int DEPTH = 64;
  localparam int WC0   = 2;
  localparam int WC1   = 0;
`ifdef DATA_RESP_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re [2];
  logic        we [2];
  logic [3:0]  st [2];
  logic [31:0] ad [2];
  logic [31:0] di [2];
  logic [31:0] dout [2];
  logic        rdy [2];
  logic        merr [2];

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  exp_t        sb0 [$];
  exp_t        sb1 [$];
  exp_t        mon_e;
  bit   [31:0] mm [2][DEPTH];
  logic [31:0] last_out [2];
  int          nresp_exp [2];
  int          nresp [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_bus_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC0)) dut0 (
    .clock(clk), .rst(rst_n), .MemReadEn(re[0]), .MemWriteEn(we[0]), .storetype(st[0]),
    .AddressBus(ad[0]), .DataMemoryInput(di[0]), .DataMemoryOutput(dout[0]),
    .MemReady(rdy[0]), .MemError(merr[0])
  );

  data_bus_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC1)) dut1 (
    .clock(clk), .rst(rst_n), .MemReadEn(re[1]), .MemWriteEn(we[1]), .storetype(st[1]),
    .AddressBus(ad[1]), .DataMemoryInput(di[1]), .DataMemoryOutput(dout[1]),
    .MemReady(rdy[1]), .MemError(merr[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: byte-addressed little-endian storage, wrapping or rejecting out-of-range addresses.
  function automatic exp_t model(input int s, input bit wr, input logic [3:0] t,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input int unsigned rc, input int wc);
    exp_t e;
    int   w;
    int   lane;
    bit   oob;
    oob = BOUNDS && (a >= 32'(4 * DEPTH));
    w   = int'((a / 4) % 32'(DEPTH));
    if (wr && !oob) begin
      if (t == 4'b0000) begin
        lane = int'(a % 4);
        mm[s][w][8*lane +: 8] = d[7:0];
      end else if (t == 4'b0001) begin
        lane = (int'(a % 4) / 2) * 2;
        mm[s][w][8*lane +: 16] = d[15:0];
      end else begin
        mm[s][w] = d;
      end
    end
    if (oob) last_out[s] = 32'h0;
    else if (!wr) last_out[s] = mm[s][w];
    e.err  = oob;
    e.data = last_out[s];
    e.cyc  = 32'(rc + 32'(wc) + 1);
    return e;
  endfunction

  // Called #1 after a rising edge with the target idle; holds the enables through the wait states.
  task automatic access(input int s, input bit rd, input bit wr, input logic [3:0] t,
                        input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   wc;
    wc = (s == 0) ? WC0 : WC1;
    re[s] = rd; we[s] = wr; st[s] = t; ad[s] = a; di[s] = d;
    e = model(s, wr, t, a, d, cyc, wc);
    if (s == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    nresp_exp[s]++;
    repeat (wc + 1) begin @(posedge clk); #1; end
    re[s] = 1'b0; we[s] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
    re[0] = 1'b0; we[0] = 1'b1; st[0] = 4'b0010; ad[0] = a; di[0] = d;
    @(posedge clk); #1;
    we[0] = 1'b0;
    repeat (WC0 + 2) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst_n) begin
        if (merr[s] && !rdy[s]) chk("error_without_ready", 32'(merr[s]), 32'h0);
        if (rdy[s]) begin
          nresp[s]++;
          if ((s == 0 && sb0.size() == 0) || (s == 1 && sb1.size() == 0)) begin
            chk("unexpected_ready", 32'(rdy[s]), 32'h0);
          end else begin
            if (s == 0) mon_e = sb0.pop_front();
            else        mon_e = sb1.pop_front();
            chk(s == 0 ? "latency_w2" : "latency_w0", cyc, mon_e.cyc);
            chk(s == 0 ? "rdata_w2" : "rdata_w0", dout[s], mon_e.data);
            chk(s == 0 ? "error_w2" : "error_w0", 32'(merr[s]), 32'(mon_e.err));
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] old;
    logic [3:0]  t;
    logic [31:0] a;
    int          op;
    int          s;
    for (int i = 0; i < 2; i++) begin
      re[i] = 1'b0; we[i] = 1'b0; st[i] = 4'd0; ad[i] = 32'h0; di[i] = 32'h0;
      last_out[i] = 32'h0; nresp_exp[i] = 0; nresp[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_dout", dout[i], 32'h0);
      chk("reset_ready", 32'(rdy[i]), 32'h0);
      chk("reset_error", 32'(merr[i]), 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32; w++) access(i, 1'b0, 1'b1, 4'b0010, 32'(w * 4), $urandom);
      access(i, 1'b0, 1'b1, 4'b0010, 32'(4 * DEPTH - 4), $urandom);
    end

    for (int i = 0; i < 2; i++) begin
      access(i, 1'b0, 1'b1, 4'b0010, 32'h20, 32'hAABBCCDD);
      access(i, 1'b0, 1'b1, 4'b0000, 32'h22, 32'hFFFFFF11);
      access(i, 1'b0, 1'b1, 4'b0001, 32'h20, 32'hFFFF3344);
      access(i, 1'b1, 1'b0, 4'b0010, 32'h20, 32'h0);
      chk("store_width", dout[i], 32'hAA113344);
      access(i, 1'b0, 1'b1, 4'b0001, 32'h27, 32'h0000BEEF);
      access(i, 1'b1, 1'b0, 4'b0001, 32'h25, 32'h0);
      chk("half_align_down", dout[i][31:16], 32'h0000BEEF);
      access(i, 1'b1, 1'b0, 4'b0010, 32'(4 * DEPTH - 1), 32'h0);
    end

    access(0, 1'b1, 1'b0, 4'b0010, 32'h40, 32'h0);
    old = mm[0][16];
    abort_store(32'h40, 32'h12345678);
    chk("abort_no_ready", 32'(nresp[0]), 32'(nresp_exp[0]));
    access(0, 1'b1, 1'b0, 4'b0010, 32'h40, 32'h0);
    chk("abort_keeps_data", dout[0], old);

    access(1, 1'b1, 1'b0, 4'b0010, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      access(i, 1'b1, 1'b1, 4'b0010, 32'h44, 32'h5A5A1234);
      access(i, 1'b1, 1'b0, 4'b0010, 32'h44, 32'h0);
      chk("both_enables_write", dout[i], 32'h5A5A1234);
    end

    for (int i = 0; i < 2; i++) begin
      old = mm[i][0];
      access(i, 1'b0, 1'b1, 4'b0010, 32'(4 * DEPTH), 32'hCAFEF00D);
      access(i, 1'b1, 1'b0, 4'b0010, 32'h0, 32'h0);
      chk("bounds_word0", dout[i], BOUNDS ? old : 32'hCAFEF00D);
    end

    old = mm[0][4];
    re[0] = 1'b0; we[0] = 1'b1; st[0] = 4'b0010; ad[0] = 32'h10; di[0] = ~old;
    @(posedge clk); #1;
    rst_n = 1'b0;
    we[0] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midreset_dout", dout[i], 32'h0);
      chk("midreset_ready", 32'(rdy[i]), 32'h0);
      chk("midreset_error", 32'(merr[i]), 32'h0);
      last_out[i] = 32'h0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 4'b0010, 32'h10, 32'h0);
    chk("reset_discards_store", dout[0], old);

    repeat (150) begin
      s  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       t = 4'b0000;
        1:       t = 4'b0001;
        2:       t = 4'b0010;
        default: t = 4'($urandom);
      endcase
      if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 127));
      else a = 32'(4 * DEPTH) * $urandom_range(1, 4) + 32'($urandom_range(0, 127));
      access(s, op != 1, op == 1 || op == 2, t, a, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (6) begin @(posedge clk); #1; end
    chk("drain_w2", 32'(sb0.size()), 32'h0);
    chk("drain_w0", 32'(sb1.size()), 32'h0);
    chk("resp_count_w2", 32'(nresp[0]), 32'(nresp_exp[0]));
    chk("resp_count_w0", 32'(nresp[1]), 32'(nresp_exp[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
